// File: rtl/mux16_merge_if.sv
// mux16_merge_if: bundles the two source channels, the merged output stream and
// the status outputs of the 2-to-1 merging arbiter.
//   a_*/b_*    : source channels (data, valid, last in; ready out of the arbiter)
//   out_*      : merged stream (data, sel, last, valid out of the arbiter; ready in)
//   fifo_count : output FIFO occupancy
//   busy       : arbiter locked mid-packet
// modport slave  : arbiter side
// modport master : environment side (sources and sink)
interface mux16_merge_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 3
);
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_last;
    logic             a_ready;

    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_last;
    logic             b_ready;

    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    logic [CNT_W-1:0] fifo_count;
    logic             busy;

    modport slave (
        input  a_data, a_valid, a_last,
        output a_ready,
        input  b_data, b_valid, b_last,
        output b_ready,
        output out_data, out_sel, out_last, out_valid,
        input  out_ready,
        output fifo_count, busy
    );

    modport master (
        output a_data, a_valid, a_last,
        input  a_ready,
        output b_data, b_valid, b_last,
        input  b_ready,
        input  out_data, out_sel, out_last, out_valid,
        output out_ready,
        input  fifo_count, busy
    );
endinterface

// File: rtl/mux16_merge.sv
// mux16_merge: round-robin, packet-locking 2-to-1 merge of two word streams
// into one tagged stream, decoupled from the sink by a small FIFO.
//   clock : rising-edge clock
//   reset : synchronous, active-high; discards buffered words and any lock
//   bus   : mux16_merge_if.slave
//           a_*/b_*    source channels, readies are combinational
//           out_*      head-of-FIFO word, zeroed while the FIFO is empty
//           fifo_count entries stored (0..DEPTH)
//           busy       arbiter locked inside a packet
module mux16_merge #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic           clock,
    input  logic           reset,
    mux16_merge_if.slave   bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ENT_W = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;      // 0 = A, 1 = B
    logic             last_grant_nxt;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             full;
    logic             a_rdy;
    logic             b_rdy;
    logic             push;
    logic             pop;
    logic             push_sel;
    logic             push_last;
    logic [WIDTH-1:0] push_data;
    logic             head_valid;
    logic [ENT_W-1:0] head_ent;

    // FIFO status; full blocks every source even when a pop coincides
    assign full       = (count == CNT_W'(DEPTH));
    assign head_valid = (count != '0);
    assign pop        = head_valid && bus.out_ready;

    // State register for the arbiter
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Grant, readies, push selection and next state
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        a_rdy          = 1'b0;
        b_rdy          = 1'b0;

        case (state)
            IDLE: begin
                if (bus.a_valid && bus.b_valid) begin
                    // tie: the channel that did not finish the previous packet wins
                    if (last_grant) a_rdy = !full;
                    else            b_rdy = !full;
                end else begin
                    a_rdy = bus.a_valid && !full;
                    b_rdy = bus.b_valid && !full;
                end
            end
            LOCK_A:  a_rdy = !full;
            LOCK_B:  b_rdy = !full;
            default: ;
        endcase

        // at most one ready is ever raised, so the sources are mutually exclusive
        push_sel  = b_rdy && bus.b_valid;
        push      = (a_rdy && bus.a_valid) || push_sel;
        push_last = push_sel ? bus.b_last : bus.a_last;
        push_data = push_sel ? bus.b_data : bus.a_data;

        if (push) begin
            if (push_last) begin
                state_nxt      = IDLE;
                last_grant_nxt = push_sel;
            end else begin
                state_nxt      = push_sel ? LOCK_B : LOCK_A;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage: entry = {sel, last, data}; no reset needed, pointers gate it
    always_ff @(posedge clock) begin
        if (push) mem[tail] <= {push_sel, push_last, push_data};
    end

    assign head_ent = mem[head];

    // Output side
    assign bus.a_ready    = a_rdy;
    assign bus.b_ready    = b_rdy;
    assign bus.out_valid  = head_valid;
    assign bus.out_data   = head_valid ? head_ent[WIDTH-1:0] : '0;
    assign bus.out_last   = head_valid & head_ent[WIDTH];
    assign bus.out_sel    = head_valid & head_ent[WIDTH+1];
    assign bus.fifo_count = count;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_mux16_merge.sv
// tb_mux16_merge: directed and randomized checks of mux16_merge against a
// queue-based reference model of the merged stream.
module tb_mux16_merge;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mux16_merge_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mux16_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // reference model: FIFO contents {sel,last,data}, packet owner, last finisher
    logic [WIDTH+1:0] q [$];
    int               owner;     // 0 none, 1 A, 2 B
    logic             last_src;  // 0 A, 1 B
    logic             acc_a;
    logic             acc_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        owner    = 0;
        last_src = 1'b1;
    endtask

    task automatic drive(input logic av, input logic [WIDTH-1:0] ad, input logic al,
                         input logic bv, input logic [WIDTH-1:0] bd, input logic bl,
                         input logic ordy);
        bus.a_valid   = av;
        bus.a_data    = ad;
        bus.a_last    = al;
        bus.b_valid   = bv;
        bus.b_data    = bd;
        bus.b_last    = bl;
        bus.out_ready = ordy;
    endtask

    function automatic void exp_ready(output logic ea, output logic eb);
        logic full;
        full = (q.size() == int'(DEPTH));
        ea = 1'b0;
        eb = 1'b0;
        if (owner == 1)      ea = !full;
        else if (owner == 2) eb = !full;
        else if (bus.a_valid && bus.b_valid) begin
            if (last_src) ea = !full;
            else          eb = !full;
        end else begin
            ea = bus.a_valid && !full;
            eb = bus.b_valid && !full;
        end
    endfunction

    // one clock cycle: check all outputs against the model, then advance both
    task automatic tick();
        logic             ea;
        logic             eb;
        logic [WIDTH+1:0] h;
        #1;
        exp_ready(ea, eb);
        h = '0;
        if (q.size() != 0) h = q[0];
        chk("a_ready",    32'(bus.a_ready),    32'(ea));
        chk("b_ready",    32'(bus.b_ready),    32'(eb));
        chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
        chk("out_valid",  32'(bus.out_valid),  32'(q.size() != 0));
        chk("out_data",   32'(bus.out_data),   32'(h[WIDTH-1:0]));
        chk("out_last",   32'(bus.out_last),   32'(h[WIDTH]));
        chk("out_sel",    32'(bus.out_sel),    32'(h[WIDTH+1]));
        chk("busy",       32'(bus.busy),       32'(owner != 0));
        acc_a = ea && bus.a_valid;
        acc_b = eb && bus.b_valid;
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            if (bus.out_ready && q.size() != 0) void'(q.pop_front());
            if (acc_a) begin
                q.push_back({1'b0, bus.a_last, bus.a_data});
                if (bus.a_last) begin owner = 0; last_src = 1'b0; end
                else owner = 1;
            end
            if (acc_b) begin
                q.push_back({1'b1, bus.b_last, bus.b_data});
                if (bus.b_last) begin owner = 0; last_src = 1'b1; end
                else owner = 2;
            end
        end
        #1;
    endtask

    task automatic idle_drain();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
            tick();
        end
        chk("drain_count", 32'(bus.fifo_count), 32'd0);
    endtask

    initial begin
        int ia;
        int ib;
        int k;
        int sent;
        int nxt_out;
        logic [WIDTH-1:0] exp_d;

        // power-up reset
        reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_out_data",   32'(bus.out_data),   32'd0);

        // single word from A, visible one cycle later
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        #1;
        chk("t1_a_ready", 32'(bus.a_ready), 32'd1);
        tick();
        chk("t1_out_data",  32'(bus.out_data),   32'h1234);
        chk("t1_out_sel",   32'(bus.out_sel),    32'd0);
        chk("t1_out_last",  32'(bus.out_last),   32'd1);
        chk("t1_count_1",   32'(bus.fifo_count), 32'd1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        chk("t1_count_0",   32'(bus.fifo_count), 32'd0);

        // alternating single-word packets from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ia = 0; ib = 0; k = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 16'(16'hAAA0 + ia), 1'b1, 1'b1, 16'(16'hBBB0 + ib), 1'b1, 1'b1);
            #1;
            if (bus.out_valid) begin
                exp_d = (k % 2 == 0) ? 16'(16'hAAA0 + k / 2) : 16'(16'hBBB0 + k / 2);
                chk("t2_sel",  32'(bus.out_sel),  32'(k % 2));
                chk("t2_data", 32'(bus.out_data), 32'(exp_d));
                k++;
            end
            tick();
            if (acc_a) ia++;
            if (acc_b) ib++;
        end
        chk("t2_words_seen", 32'(k >= 10), 32'd1);
        idle_drain();

        // 3-beat packet from A holds off B
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        chk("t3_busy_1", 32'(bus.busy), 32'd1);
        drive(1'b1, 16'h0002, 1'b0, 1'b1, 16'hBBB9, 1'b1, 1'b1);
        #1;
        chk("t3_b_ready_2", 32'(bus.b_ready), 32'd0);
        tick();
        drive(1'b1, 16'h0003, 1'b1, 1'b1, 16'hBBB9, 1'b1, 1'b1);
        #1;
        chk("t3_b_ready_3", 32'(bus.b_ready), 32'd0);
        chk("t3_busy_3",    32'(bus.busy),    32'd1);
        tick();
        drive(1'b1, 16'h0004, 1'b1, 1'b1, 16'hBBB9, 1'b1, 1'b1);
        #1;
        chk("t3_b_grant",  32'(bus.b_ready), 32'd1);
        chk("t3_a_wait",   32'(bus.a_ready), 32'd0);
        chk("t3_busy_end", 32'(bus.busy),    32'd0);
        tick();
        idle_drain();

        // back-pressure: only DEPTH words fit, then drain in order
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 16'(sent + 1), 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            tick();
            if (acc_a) sent++;
        end
        drive(1'b1, 16'(sent + 1), 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("t4_count_full", 32'(bus.fifo_count), 32'd4);
        chk("t4_a_blocked",  32'(bus.a_ready),    32'd0);
        nxt_out = 1;
        for (int c = 0; c < 20; c++) begin
            drive(sent < 6, 16'(sent + 1), 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
            #1;
            chk("t4_max", 32'(bus.fifo_count <= 3'(DEPTH)), 32'd1);
            if (bus.out_valid) begin
                chk("t4_order", 32'(bus.out_data), 32'(nxt_out));
                nxt_out++;
            end
            tick();
            if (acc_a) sent++;
        end
        chk("t4_all_out", 32'(nxt_out), 32'd7);

        // reset in the middle of a locked packet
        drive(1'b1, 16'h0051, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        tick();
        reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0B05, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        #1;
        chk("t5_busy",      32'(bus.busy),       32'd0);
        chk("t5_out_valid", 32'(bus.out_valid),  32'd0);
        chk("t5_count",     32'(bus.fifo_count), 32'd0);
        chk("t5_out_data",  32'(bus.out_data),   32'd0);
        chk("t5_b_ready",   32'(bus.b_ready),    32'd1);
        tick();
        idle_drain();

        // full FIFO: pop without push, then push+pop
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'h0600 + i), 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 16'h0610, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        #1;
        chk("t6_a_ready_full", 32'(bus.a_ready),    32'd0);
        chk("t6_count_4",      32'(bus.fifo_count), 32'd4);
        tick();
        #1;
        chk("t6_count_3a",     32'(bus.fifo_count), 32'd3);
        chk("t6_a_ready_back", 32'(bus.a_ready),    32'd1);
        tick();
        chk("t6_count_3b",     32'(bus.fifo_count), 32'd3);
        idle_drain();

        // randomized traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0;
        // finish any open packet, then drain
        for (int i = 0; i < 4; i++) begin
            drive(owner == 1, 16'h0EEE, 1'b1, owner == 2, 16'h0FFF, 1'b1, 1'b1);
            tick();
        end
        idle_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mux16_merge.md
Name: mux16_merge

Overview:
- 2-to-1 merging arbiter for 16-bit word streams; the inverse of the 16-bit demultiplexer stage.
- Accepts words from two valid/ready source channels (A, B) and serialises them into one output stream.
- Each output word is tagged with `out_sel` (0 = A, 1 = B), so a downstream 16-bit demux can re-split the stream.
- Arbitration is round-robin with packet locking; an internal FIFO decouples the output from the sources.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 4, output FIFO entries; must be a power of 2, at least 2.
- CNT_W, 3, width of `fifo_count`; must equal log2(DEPTH)+1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a_data  input  WIDTH  channel A word.
- a_valid  input  1  channel A word present.
- a_last  input  1  channel A word ends its packet.
- a_ready  output  1  channel A word accepted this cycle when a_valid=1.
- b_data  input  WIDTH  channel B word.
- b_valid  input  1  channel B word present.
- b_last  input  1  channel B word ends its packet.
- b_ready  output  1  channel B word accepted this cycle when b_valid=1.
- out_data  output  WIDTH  head-of-FIFO word.
- out_sel  output  1  source of the head word (0 = A, 1 = B).
- out_last  output  1  head word ends its packet.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream consumes the head word.
- fifo_count  output  CNT_W  entries currently stored, 0..DEPTH.
- busy  output  1  arbiter is locked mid-packet.

Behaviour:
- Reset, applied on a clock edge while reset=1:
  - state=IDLE, last_grant=B (so A wins the first tie), FIFO pointers=0, fifo_count=0, out_valid=0.
  - Reset wins over every simultaneous event, including mid-packet lock and FIFO traffic. Buffered words are discarded and any partially merged packet is dropped.
- full = (fifo_count==DEPTH).
- Ready signals are combinational from state, full and the valid inputs:
  - No source is ever readied while full, even if a pop happens in the same cycle.
  - Any combination of a_valid/b_valid is legal every cycle.
- State IDLE:
  - Only a_valid=1: a_ready=!full, b_ready=0.
  - Only b_valid=1: b_ready=!full, a_ready=0.
  - Both valid: grant goes to the channel not equal to last_grant; only that channel's ready is raised, gated by !full.
  - Accepted beat with last=0: go to LOCK_A or LOCK_B for that channel.
  - Accepted beat with last=1: stay in IDLE; last_grant = that channel.
- State LOCK_x:
  - x_ready=!full; the other channel's ready=0 regardless of its valid.
  - Accepted beat with x_last=1: go to IDLE; last_grant=x.
  - x_valid may drop mid-packet; the lock holds indefinitely.
- Transfer rules:
  - Source transfer: valid&&ready on the rising edge. The entry {sel, last, data} is written at the tail and the tail pointer advances, wrapping modulo DEPTH.
  - Output transfer: out_valid&&out_ready; the head pointer advances modulo DEPTH.
- Counts and outputs:
  - Push and pop in the same cycle leave fifo_count unchanged.
  - out_valid = (fifo_count!=0).
  - out_data, out_sel and out_last come from the head entry when out_valid=1 and are forced to 0 when out_valid=0.
  - Latency: a word accepted on edge N is visible at the output after edge N (cycle N+1) when the FIFO was empty.
  - Ordering is preserved and no words are duplicated or lost.
- busy = (state != IDLE).
- Throughput: with out_ready held at 1, one word per cycle sustained.

Test Plan:
1. Reset, then A sends 0x1234 with last=1, out_ready=1 -> a_ready=1 that cycle; next cycle out_valid=1, out_data=0x1234, out_sel=0, out_last=1; fifo_count 1 then 0.
2. Both valid every cycle, all single-word packets (A=0xAAAn, B=0xBBBn), out_ready=1 -> output order A0,B0,A1,B1,…; out_sel toggles 0,1,0,1.
3. A sends 3-beat packet 0x0001,0x0002,0x0003 (last on the third) while b_valid=1 throughout -> b_ready=0 and busy=1 until 0x0003 is accepted; next grant goes to B.
4. out_ready=0, A streams 6 single-word packets -> 4 accepted, fifo_count=4, a_ready=0; raise out_ready -> drain in order 1..6 with no loss; fifo_count never exceeds 4.
5. A packet mid-lock (1 beat of 3 accepted), reset=1 for one cycle -> next cycle state IDLE, busy=0, out_valid=0, fifo_count=0, out_data=0; B (valid) is then granted immediately.
6. Full FIFO with out_ready=1 and a_valid=1 -> pop occurs and a_ready=0 that cycle; a_ready=1 the following cycle; fifo_count goes 4, 3, 3.
